// File: rtl/bram_pkg.sv
// rtl/bram_pkg.sv - shared types and default geometry for the BRAM arbiter
package bram_pkg;

    localparam int unsigned BRAM_ADDR_WIDTH   = 10;
    localparam int unsigned BRAM_DATA_WIDTH   = 32;
    localparam int unsigned BRAM_READ_LATENCY = 2;

    typedef enum logic [0:0] {
        RESET_WAIT = 1'b0,
        RUN        = 1'b1
    } arb_state_e;

    // One in-flight read: whether the slot holds a read, and which requester issued it.
    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// rtl/bram_rd_tag_pipe.sv - fixed-depth shift register of read tags aligned to BRAM read latency
module bram_rd_tag_pipe
    import bram_pkg::*;
#(
    parameter int unsigned DEPTH = BRAM_READ_LATENCY
) (
    input  logic    clk,
    input  logic    clr_i,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t stage_q [DEPTH];
    rd_tag_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_i;
        for (int i = 1; i < int'(DEPTH); i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (clr_i) begin
                stage_q[i] <= '0;
            end else begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - two-requester round-robin arbiter onto a single BRAM port with read response routing
module bram_arbiter
    import bram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = BRAM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH   = BRAM_DATA_WIDTH,
    parameter int unsigned READ_LATENCY = BRAM_READ_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd0_tvalid,
    output logic                  cmd0_tready,
    input  logic                  cmd0_we,
    input  logic [ADDR_WIDTH-1:0] cmd0_addr,
    input  logic [DATA_WIDTH-1:0] cmd0_wdata,

    input  logic                  cmd1_tvalid,
    output logic                  cmd1_tready,
    input  logic                  cmd1_we,
    input  logic [ADDR_WIDTH-1:0] cmd1_addr,
    input  logic [DATA_WIDTH-1:0] cmd1_wdata,

    output logic                  rsp0_tvalid,
    output logic [DATA_WIDTH-1:0] rsp0_tdata,
    output logic                  rsp1_tvalid,
    output logic [DATA_WIDTH-1:0] rsp1_tdata,

    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    input  logic                  bram_rst_busy,

    output logic                  busy
);

    arb_state_e state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic       gnt0, gnt1, accept, sel_we;
    rd_tag_t    tag_in, tag_out;
    logic       rsp_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_WAIT;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt0         = 1'b0;
        gnt1         = 1'b0;
        sel_we       = 1'b0;
        bram_addr    = '0;
        bram_din     = '0;

        case (state_q)
            RESET_WAIT: if (!bram_rst_busy) state_d = RUN;
            RUN:        state_d = RUN;
            default:    state_d = RESET_WAIT;
        endcase

        // Grants are suppressed during the reset cycle itself so nothing issues that would be cleared.
        if (state_q == RUN && !reset) begin
            gnt0 = cmd0_tvalid && (!cmd1_tvalid ||  last_grant_q);
            gnt1 = cmd1_tvalid && (!cmd0_tvalid || !last_grant_q);
        end

        if (gnt1) begin
            sel_we    = cmd1_we;
            bram_addr = cmd1_addr;
            bram_din  = cmd1_wdata;
        end else if (gnt0) begin
            sel_we    = cmd0_we;
            bram_addr = cmd0_addr;
            bram_din  = cmd0_wdata;
        end

        if (gnt0 || gnt1) begin
            last_grant_d = gnt1;
        end
    end

    assign accept      = gnt0 | gnt1;
    assign cmd0_tready = gnt0;
    assign cmd1_tready = gnt1;
    assign bram_en     = accept;
    assign bram_we     = accept & sel_we;
    assign busy        = (state_q != RUN);

    assign tag_in.valid = accept & ~sel_we;
    assign tag_in.id    = gnt1;

    bram_rd_tag_pipe #(
        .DEPTH (READ_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .clr_i (reset),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    // A tag emerging while reset is held belongs to a read that reset is discarding.
    assign rsp_fire    = tag_out.valid & ~reset;
    assign rsp0_tvalid = rsp_fire & ~tag_out.id;
    assign rsp1_tvalid = rsp_fire &  tag_out.id;
    assign rsp0_tdata  = rsp0_tvalid ? bram_dout : '0;
    assign rsp1_tdata  = rsp1_tvalid ? bram_dout : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - directed bench for bram_arbiter with a 2-cycle BRAM model
module tb_bram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd0_tvalid, cmd0_tready, cmd0_we;
    logic [AW-1:0] cmd0_addr;
    logic [DW-1:0] cmd0_wdata;
    logic          cmd1_tvalid, cmd1_tready, cmd1_we;
    logic [AW-1:0] cmd1_addr;
    logic [DW-1:0] cmd1_wdata;
    logic          rsp0_tvalid, rsp1_tvalid;
    logic [DW-1:0] rsp0_tdata, rsp1_tdata;
    logic          bram_en, bram_we, bram_rst_busy, busy;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_din;
    logic [DW-1:0] bram_dout = '0;

    bram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .cmd0_tvalid(cmd0_tvalid), .cmd0_tready(cmd0_tready), .cmd0_we(cmd0_we),
        .cmd0_addr(cmd0_addr), .cmd0_wdata(cmd0_wdata),
        .cmd1_tvalid(cmd1_tvalid), .cmd1_tready(cmd1_tready), .cmd1_we(cmd1_we),
        .cmd1_addr(cmd1_addr), .cmd1_wdata(cmd1_wdata),
        .rsp0_tvalid(rsp0_tvalid), .rsp0_tdata(rsp0_tdata),
        .rsp1_tvalid(rsp1_tvalid), .rsp1_tdata(rsp1_tdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout), .bram_rst_busy(bram_rst_busy), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // BRAM model: registered read, then registered output -> dout valid 2 cycles after en.
    logic [DW-1:0] mem    [2**AW];
    logic [DW-1:0] shadow [2**AW];
    logic [DW-1:0] rd_s1 = '0;
    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) mem[bram_addr] <= bram_din;
            rd_s1 <= mem[bram_addr];
        end
        bram_dout <= rd_s1;
    end

    typedef struct {
        int          due;
        logic        id;
        logic [31:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [31:0]   rsp0_log[$];
    logic [31:0]   rsp1_log[$];
    int            rsp1_cyc[$];

    always @(negedge clk) begin : monitor
        exp_t        e;
        logic        acc0, acc1, w;
        logic [AW-1:0] a;
        if (reset) begin
            exp_q.delete();
            expect_eq("rsp_during_reset", 32'({rsp1_tvalid, rsp0_tvalid}), 32'd0);
        end else begin
            acc0 = cmd0_tvalid && cmd0_tready;
            acc1 = cmd1_tvalid && cmd1_tready;
            expect_eq("tready_exclusive", 32'(cmd0_tready & cmd1_tready), 32'd0);
            expect_eq("bram_en_vs_accept", 32'(bram_en), 32'(acc0 | acc1));
            if (!rsp0_tvalid) expect_eq("rsp0_idle_zero", rsp0_tdata, 32'd0);
            if (!rsp1_tvalid) expect_eq("rsp1_idle_zero", rsp1_tdata, 32'd0);
            if (rsp0_tvalid || rsp1_tvalid) begin
                expect_eq("rsp_single", 32'(rsp0_tvalid & rsp1_tvalid), 32'd0);
                if (exp_q.size() == 0) begin
                    expect_eq("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    expect_eq("rsp_id", 32'(rsp1_tvalid), 32'(e.id));
                    expect_eq("rsp_cycle", cyc, e.due);
                    expect_eq("rsp_data", rsp1_tvalid ? rsp1_tdata : rsp0_tdata, e.data);
                end
                if (rsp0_tvalid) rsp0_log.push_back(rsp0_tdata);
                if (rsp1_tvalid) begin
                    rsp1_log.push_back(rsp1_tdata);
                    rsp1_cyc.push_back(cyc);
                end
            end
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                expect_eq("rsp_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end
            if (acc0 || acc1) begin
                w = acc1 ? cmd1_we : cmd0_we;
                a = acc1 ? cmd1_addr : cmd0_addr;
                if (w) shadow[a] = acc1 ? cmd1_wdata : cmd0_wdata;
                else begin
                    e.due  = cyc + RL;
                    e.id   = acc1;
                    e.data = shadow[a];
                    exp_q.push_back(e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rsp0_log.delete();
        rsp1_log.delete();
        rsp1_cyc.delete();
    endtask

    task automatic issue(input int n, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, output int t);
        logic rdy;
        if (n == 0) begin
            cmd0_we = we; cmd0_addr = a; cmd0_wdata = d; cmd0_tvalid = 1'b1;
        end else begin
            cmd1_we = we; cmd1_addr = a; cmd1_wdata = d; cmd1_tvalid = 1'b1;
        end
        #1;
        rdy = (n == 0) ? cmd0_tready : cmd1_tready;
        for (int k = 0; k < 20 && !rdy; k++) begin
            step();
            rdy = (n == 0) ? cmd0_tready : cmd1_tready;
        end
        expect_eq("issue_granted", 32'(rdy), 32'd1);
        t = cyc;
        step();
        cmd0_tvalid = 1'b0;
        cmd1_tvalid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int          t, lat;
        logic        got;
        logic [31:0] d;
        int          i0, i1;

        for (int i = 0; i < 2**AW; i++) begin
            mem[i]    = 32'hA000_0000 | 32'(i);
            shadow[i] = 32'hA000_0000 | 32'(i);
        end

        // Reset with the BRAM still busy; a pending write must wait for RUN.
        reset = 1'b1; bram_rst_busy = 1'b1;
        cmd0_tvalid = 1'b1; cmd0_we = 1'b1; cmd0_addr = 10'h100; cmd0_wdata = 32'h1111_1111;
        cmd1_tvalid = 1'b0; cmd1_we = 1'b0; cmd1_addr = '0; cmd1_wdata = '0;
        step();
        expect_eq("reset_busy", 32'(busy), 32'd1);
        expect_eq("reset_tready0", 32'(cmd0_tready), 32'd0);
        expect_eq("reset_bram_en", 32'(bram_en), 32'd0);
        expect_eq("reset_rsp0", 32'(rsp0_tvalid), 32'd0);
        reset = 1'b0;
        repeat (3) begin
            step();
            expect_eq("rstbusy_busy", 32'(busy), 32'd1);
            expect_eq("rstbusy_tready0", 32'(cmd0_tready), 32'd0);
            expect_eq("rstbusy_bram_we", 32'(bram_we), 32'd0);
        end
        bram_rst_busy = 1'b0;
        #1;
        expect_eq("drop_cycle_busy", 32'(busy), 32'd1);
        expect_eq("drop_cycle_tready0", 32'(cmd0_tready), 32'd0);
        step();
        expect_eq("run_busy", 32'(busy), 32'd0);
        expect_eq("run_tready0", 32'(cmd0_tready), 32'd1);
        expect_eq("run_bram_we", 32'(bram_we), 32'd1);
        expect_eq("run_bram_addr", 32'(bram_addr), 32'h100);
        expect_eq("run_bram_din", bram_din, 32'h1111_1111);
        step();
        cmd0_tvalid = 1'b0;
        #1;
        expect_eq("idle_bram_en", 32'(bram_en), 32'd0);
        expect_eq("idle_bram_we", 32'(bram_we), 32'd0);

        // Write then read back the top address from requester 0.
        clear_logs();
        issue(0, 1'b1, 10'h3FF, 32'hDEAD_BEEF, t);
        issue(0, 1'b0, 10'h3FF, 32'h0, t);
        got = 1'b0; lat = -1; d = '0;
        for (int k = 0; k < 8; k++) begin
            if (rsp0_tvalid) begin
                got = 1'b1; lat = cyc - t; d = rsp0_tdata;
                break;
            end
            step();
        end
        expect_eq("rw_rsp_seen", 32'(got), 32'd1);
        expect_eq("rw_latency", lat, 32'd2);
        expect_eq("rw_data", d, 32'hDEAD_BEEF);
        repeat (3) step();
        expect_eq("rw_rsp1_count", rsp1_log.size(), 32'd0);
        expect_eq("rw_rsp0_count", rsp0_log.size(), 32'd1);

        // Requester 1 goes last so the following tie starts with requester 0.
        issue(1, 1'b1, 10'h200, 32'hCAFE_F00D, t);
        clear_logs();
        i0 = 0; i1 = 0;
        cmd0_tvalid = 1'b1; cmd0_we = 1'b0;
        cmd1_tvalid = 1'b1; cmd1_we = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cmd0_addr = 10'(10'h10 + i0);
            cmd1_addr = 10'(10'h20 + i1);
            #1;
            expect_eq("rr_grant", 32'(cmd1_tready), 32'(c % 2));
            expect_eq("rr_one_hot", 32'(cmd0_tready ^ cmd1_tready), 32'd1);
            if (cmd0_tready) i0++;
            if (cmd1_tready) i1++;
            step();
        end
        cmd0_tvalid = 1'b0; cmd1_tvalid = 1'b0;
        repeat (4) step();
        expect_eq("rr_rsp0_count", rsp0_log.size(), 32'd4);
        expect_eq("rr_rsp1_count", rsp1_log.size(), 32'd4);
        if (rsp0_log.size() == 4 && rsp1_log.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                expect_eq("rr_rsp0_data", rsp0_log[k], 32'hA000_0010 + 32'(k));
                expect_eq("rr_rsp1_data", rsp1_log[k], 32'hA000_0020 + 32'(k));
            end
        end

        // Requester 1 streams 16 back-to-back reads.
        clear_logs();
        cmd1_tvalid = 1'b1; cmd1_we = 1'b0;
        for (int i = 0; i < 16; i++) begin
            cmd1_addr = 10'(i);
            #1;
            expect_eq("stream_tready1", 32'(cmd1_tready), 32'd1);
            step();
        end
        cmd1_tvalid = 1'b0;
        repeat (4) step();
        expect_eq("stream_count", rsp1_log.size(), 32'd16);
        if (rsp1_log.size() == 16) begin
            for (int i = 0; i < 16; i++) begin
                expect_eq("stream_data", rsp1_log[i], 32'hA000_0000 + 32'(i));
                expect_eq("stream_gap", rsp1_cyc[i] - rsp1_cyc[0], i);
            end
        end

        // Two reads in flight, then reset one cycle later: both must vanish.
        clear_logs();
        cmd0_tvalid = 1'b1; cmd0_we = 1'b0; cmd0_addr = 10'h001;
        cmd1_tvalid = 1'b1; cmd1_we = 1'b0; cmd1_addr = 10'h002;
        #1;
        expect_eq("flush_first_grant0", 32'(cmd0_tready), 32'd1);
        step();
        cmd0_tvalid = 1'b0;
        #1;
        expect_eq("flush_second_grant1", 32'(cmd1_tready), 32'd1);
        step();
        cmd1_tvalid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0; bram_rst_busy = 1'b1;
        repeat (3) begin
            step();
            expect_eq("flush_rstbusy_busy", 32'(busy), 32'd1);
        end
        bram_rst_busy = 1'b0;
        for (int k = 0; k < 5 && busy; k++) step();
        expect_eq("flush_back_to_run", 32'(busy), 32'd0);
        expect_eq("flush_rsp0_count", rsp0_log.size(), 32'd0);
        expect_eq("flush_rsp1_count", rsp1_log.size(), 32'd0);

        // After reset the first tie goes to requester 0; then address-wrap writes and reads.
        cmd0_tvalid = 1'b1; cmd0_we = 1'b1; cmd0_addr = 10'h3FF; cmd0_wdata = 32'h1234_5678;
        cmd1_tvalid = 1'b1; cmd1_we = 1'b1; cmd1_addr = 10'h050; cmd1_wdata = 32'h55AA_55AA;
        #1;
        expect_eq("tie_after_reset", 32'(cmd0_tready), 32'd1);
        step();
        cmd0_tvalid = 1'b0;
        #1;
        expect_eq("tie_then_req1", 32'(cmd1_tready), 32'd1);
        step();
        cmd1_tvalid = 1'b0;
        clear_logs();
        issue(0, 1'b1, 10'h000, 32'h9ABC_DEF0, t);
        issue(0, 1'b0, 10'h3FF, 32'h0, t);
        issue(0, 1'b0, 10'h000, 32'h0, t);
        repeat (4) step();
        expect_eq("wrap_rsp_count", rsp0_log.size(), 32'd2);
        if (rsp0_log.size() == 2) begin
            expect_eq("wrap_data_3ff", rsp0_log[0], 32'h1234_5678);
            expect_eq("wrap_data_000", rsp0_log[1], 32'h9ABC_DEF0);
        end

        repeat (3) step();
        expect_eq("pending_rsp", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
